// File: rtl/regfile_pkg.sv
// Package for the multi-port register file.
// Holds the default parameter values and the commit-decision function that
// decides, for one clock cycle, which write ports actually update the array,
// how many distinct registers change, and whether the two ports collided.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 16;
  localparam int DEFAULT_NUM_RD   = 2;
  localparam int DEFAULT_ZERO_R0  = 1;

  // Widest address the decision function accepts (up to 256 registers).
  // Callers zero-extend their narrower addresses to this width.
  localparam int ADDR_MAX = 8;

  typedef struct packed {
    logic       commit_a;  // port A updates the array this cycle
    logic       commit_b;  // port B updates the array this cycle
    logic [1:0] count;     // distinct registers updated (0..2)
    logic       collide;   // both enables high on the same address
  } commit_t;

  // Port B wins a same-address conflict, so A is suppressed and the pair
  // counts as a single update. Writes to register 0 are dropped when it is
  // hard-wired to zero. The collision flag ignores the register-0 rule.
  function automatic commit_t commit_decide(
    input logic                write_enable_a,
    input logic                write_enable_b,
    input logic [ADDR_MAX-1:0] write_register_a,
    input logic [ADDR_MAX-1:0] write_register_b,
    input logic                zero_r0
  );
    commit_t c;
    c.collide  = write_enable_a && write_enable_b &&
                 (write_register_a == write_register_b);
    c.commit_b = write_enable_b && !(zero_r0 && (write_register_b == '0));
    c.commit_a = write_enable_a && !(zero_r0 && (write_register_a == '0)) &&
                 !c.collide;
    c.count    = 2'(c.commit_a) + 2'(c.commit_b);
    return c;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// One read port of the register file: selects the addressed register from
// the flop array and overrides it with same-cycle write data (B over A).
// Register 0 reads as zero when ZERO_R0 is set, with no bypass.
// Ports:
//   regs              flattened register array (from the top)
//   read_register     read address for this port
//   write_register_*  write addresses of ports A and B
//   write_data_*      write data of ports A and B
//   write_enable_*    write strobes of ports A and B
//   data              combinational read data
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_R0  = 1
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]               read_register,
  input  logic [ADDR_W-1:0]               write_register_a,
  input  logic [ADDR_W-1:0]               write_register_b,
  input  logic [DATA_W-1:0]               write_data_a,
  input  logic [DATA_W-1:0]               write_data_b,
  input  logic                            write_enable_a,
  input  logic                            write_enable_b,
  output logic [DATA_W-1:0]               data
);

  // Later assignments take priority: array < port A < port B < zero rule.
  // NOTE: data gets a default on entry so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    data = regs[read_register];
    if (write_enable_a && (write_register_a == read_register))
      data = write_data_a;
    if (write_enable_b && (write_register_b == read_register))
      data = write_data_b;
    if ((ZERO_R0 != 0) && (read_register == '0))
      data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports with write
// bypass, two write ports (B wins on conflict), optional hard-wired zero
// register, a registered collision flag and a saturating update counter.
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   read_register     NUM_RD read addresses
//   data              NUM_RD read data words (combinational)
//   write_register_a/b, write_data_a/b, write_enable_a/b  write ports A, B
//   collision         high for one cycle after an A/B same-address write
//   write_count       saturating count of committed register updates
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEFAULT_DATA_W,
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int NUM_RD   = DEFAULT_NUM_RD,
  parameter  int ZERO_R0  = DEFAULT_ZERO_R0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] read_register,
  output logic [NUM_RD-1:0][DATA_W-1:0] data,
  input  logic [ADDR_W-1:0]             write_register_a,
  input  logic [ADDR_W-1:0]             write_register_b,
  input  logic [DATA_W-1:0]             write_data_a,
  input  logic [DATA_W-1:0]             write_data_b,
  input  logic                          write_enable_a,
  input  logic                          write_enable_b,
  output logic                          collision,
  output logic [15:0]                   write_count
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  commit_t                         cd;
  logic [16:0]                     count_sum;

  assign cd = commit_decide(write_enable_a, write_enable_b,
                            ADDR_MAX'(write_register_a),
                            ADDR_MAX'(write_register_b),
                            ZERO_R0 != 0);

  // One extra bit so the saturation check sees the carry out.
  assign count_sum = {1'b0, write_count} + 17'(cd.count);

  // NOTE: the whole array is cleared on reset because the architecture
  // requires registers to read 0 afterwards; this only works as flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      // NOTE: non-blocking assignments keep both ports' updates ordered by
      // edge, and B is written last so it wins if both ever targeted one
      // register (commit_decide already masks A in that case).
      if (cd.commit_a) regs[write_register_a] <= write_data_a;
      if (cd.commit_b) regs[write_register_b] <= write_data_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision   <= 1'b0;
      write_count <= '0;
    end else begin
      collision   <= cd.collide;
      write_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end

  // Bypass is purely combinational, so it still drives data during reset.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_bypass #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
    ) u_bypass (
      .regs            (regs),
      .read_register   (read_register[i]),
      .write_register_a(write_register_a),
      .write_register_b(write_register_b),
      .write_data_a    (write_data_a),
      .write_data_b    (write_data_b),
      .write_enable_a  (write_enable_a),
      .write_enable_b  (write_enable_b),
      .data            (data[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters
// (32-bit data, 16 registers, 2 read ports, register 0 hard-wired to zero).
module tb_regfile_mp;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][3:0]  read_register;
  logic [1:0][31:0] data;
  logic [3:0]       write_register_a, write_register_b;
  logic [31:0]      write_data_a, write_data_b;
  logic             write_enable_a, write_enable_b;
  logic             collision;
  logic [15:0]      write_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .read_register   (read_register),
    .data            (data),
    .write_register_a(write_register_a),
    .write_register_b(write_register_b),
    .write_data_a    (write_data_a),
    .write_data_b    (write_data_b),
    .write_enable_a  (write_enable_a),
    .write_enable_b  (write_enable_b),
    .collision       (collision),
    .write_count     (write_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    write_enable_a = 1'b0;
    write_enable_b = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    read_register    = '0;
    write_register_a = 4'd3;
    write_register_b = 4'd0;
    write_data_a     = 32'hDEAD;
    write_data_b     = 32'h0;
    write_enable_a   = 1'b1;
    write_enable_b   = 1'b0;
    read_register[0] = 4'd3;
    #1;
    // Bypass still drives data while reset is asserted.
    check("rst_bypass", data[0], 32'hDEAD);
    tick();
    tick();
    rst_n = 1'b1;
    idle_writes();
    #1;
    check("rst_reg3", data[0], 32'h0);
    check("rst_count", 32'(write_count), 32'h0);
    check("rst_coll", 32'(collision), 32'h0);

    // Single write, read back next cycle.
    write_register_a = 4'd5;
    write_data_a     = 32'h12345678;
    write_enable_a   = 1'b1;
    tick();
    idle_writes();
    read_register[0] = 4'd5;
    #1;
    check("wr_read5", data[0], 32'h12345678);
    check("wr_count1", 32'(write_count), 32'd1);

    // Port B bypass to read port 1 in the same cycle.
    read_register[1] = 4'd7;
    write_register_b = 4'd7;
    write_data_b     = 32'h87654321;
    write_enable_b   = 1'b1;
    #1;
    check("byp_b", data[1], 32'h87654321);
    tick();
    idle_writes();
    #1;
    check("byp_b_stored", data[1], 32'h87654321);
    check("byp_count2", 32'(write_count), 32'd2);

    // A/B collision on register 2: B wins bypass and commit, counted once.
    write_register_a = 4'd2;
    write_data_a     = 32'h1111;
    write_register_b = 4'd2;
    write_data_b     = 32'h2222;
    write_enable_a   = 1'b1;
    write_enable_b   = 1'b1;
    read_register[0] = 4'd2;
    #1;
    check("coll_byp", data[0], 32'h2222);
    check("coll_pre", 32'(collision), 32'h0);
    tick();
    idle_writes();
    #1;
    check("coll_flag", 32'(collision), 32'h1);
    check("coll_reg2", data[0], 32'h2222);
    check("coll_count3", 32'(write_count), 32'd3);
    tick();
    check("coll_clear", 32'(collision), 32'h0);

    // Port A bypass alone.
    write_register_a = 4'd9;
    write_data_a     = 32'hABCD;
    write_enable_a   = 1'b1;
    read_register[1] = 4'd9;
    #1;
    check("byp_a", data[1], 32'hABCD);
    tick();
    // Two distinct registers in one cycle.
    write_register_a = 4'd10;
    write_data_a     = 32'hA0A0;
    write_register_b = 4'd11;
    write_data_b     = 32'hB0B0;
    write_enable_b   = 1'b1;
    tick();
    idle_writes();
    read_register[0] = 4'd10;
    read_register[1] = 4'd11;
    #1;
    check("dual_r10", data[0], 32'hA0A0);
    check("dual_r11", data[1], 32'hB0B0);
    check("dual_count6", 32'(write_count), 32'd6);

    // Collision at address 0 still flags, but nothing commits.
    write_register_a = 4'd0;
    write_register_b = 4'd0;
    write_data_a     = 32'h5;
    write_data_b     = 32'h6;
    write_enable_a   = 1'b1;
    write_enable_b   = 1'b1;
    tick();
    idle_writes();
    #1;
    check("coll0_flag", 32'(collision), 32'h1);
    check("coll0_count", 32'(write_count), 32'd6);

    // R0 write dropped, no bypass, no count.
    write_register_a = 4'd0;
    write_data_a     = 32'hFFFF_FFFF;
    write_enable_a   = 1'b1;
    read_register[0] = 4'd0;
    #1;
    check("r0_nobyp", data[0], 32'h0);
    tick();
    idle_writes();
    #1;
    check("r0_read", data[0], 32'h0);
    check("r0_count", 32'(write_count), 32'd6);

    // Drive the counter up to 16'hFFFE with paired distinct writes.
    exp_cnt          = 6;
    write_register_a = 4'd1;
    write_register_b = 4'd4;
    write_data_a     = 32'h1;
    write_data_b     = 32'h4;
    while (exp_cnt < 32'hFFFE) begin
      write_enable_a = 1'b1;
      write_enable_b = (32'hFFFE - exp_cnt) >= 2;
      exp_cnt += write_enable_b ? 2 : 1;
      tick();
    end
    idle_writes();
    #1;
    check("sat_pre", 32'(write_count), 32'hFFFE);
    write_enable_a = 1'b1;
    write_enable_b = 1'b1;
    tick();
    check("sat_hit", 32'(write_count), 32'hFFFF);
    tick();
    idle_writes();
    #1;
    check("sat_hold", 32'(write_count), 32'hFFFF);

    // Reset clears state mid-run.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    read_register[0] = 4'd1;
    #1;
    check("rst2_count", 32'(write_count), 32'h0);
    check("rst2_reg1", data[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
